// File: rtl/cache_line_sequencer.sv
// cache_line_sequencer: turns one cache miss/flush into an optional writeback burst
// followed by an optional fill burst on the burst memory controller.
module cache_line_sequencer #(
    parameter int LINE_WORDS = 16,
    parameter int SRAM_AW    = 10,
    parameter int LINE_IDX_W = 6,
    parameter int TIMEOUT    = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [LINE_IDX_W-1:0] req_line,
    input  logic                  req_wb,
    input  logic [31:0]           req_wb_addr,
    input  logic                  req_fill,
    input  logic [31:0]           req_fill_addr,
    output logic                  mc_ce,
    output logic                  mc_we,
    output logic [SRAM_AW-1:0]    mc_sram_addr,
    output logic [31:0]           mc_ext_addr,
    input  logic                  mc_busy,
    input  logic [9:0]            mc_progress,
    output logic                  active,
    output logic [LINE_IDX_W-1:0] active_line,
    output logic                  done_valid,
    output logic                  done_err,
    output logic [9:0]            wb_words
);
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {
        IDLE, WB_ISSUE, WB_WAIT_BUSY, WB_WAIT_DONE,
        FILL_ISSUE, FILL_WAIT_BUSY, FILL_WAIT_DONE, DONE
    } state_t;
    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  fill_q, fill_d, err_q, err_d;
    logic [31:0]           wb_addr_q, wb_addr_d, fill_addr_q, fill_addr_d;
    logic                  mc_ce_q, mc_ce_d, mc_we_q, mc_we_d;
    logic [SRAM_AW-1:0]    mc_sram_addr_q, mc_sram_addr_d;
    logic [31:0]           mc_ext_addr_q, mc_ext_addr_d;
    logic                  active_q, active_d, done_valid_q, done_valid_d, done_err_q, done_err_d;
    logic [LINE_IDX_W-1:0] active_line_q, active_line_d;
    logic [9:0]            wb_words_q, wb_words_d;
    logic [SRAM_AW-1:0]    line_base;
    logic                  waiting, expired, is_wb;
    assign line_base = SRAM_AW'({active_line_q, {OFF_W{1'b0}}});
    assign waiting   = (state_q != IDLE) && (state_q != DONE);
    assign expired   = waiting && (cnt_q == CNT_W'(TIMEOUT - 1));
    assign is_wb     = (state_q == WB_ISSUE);
    always_comb begin
        state_d        = state_q;
        fill_d         = fill_q;
        err_d          = err_q;
        wb_addr_d      = wb_addr_q;
        fill_addr_d    = fill_addr_q;
        mc_ce_d        = 1'b0;
        mc_we_d        = mc_we_q;
        mc_sram_addr_d = mc_sram_addr_q;
        mc_ext_addr_d  = mc_ext_addr_q;
        active_d       = active_q;
        active_line_d  = active_line_q;
        wb_words_d     = wb_words_q;
        case (state_q)
            IDLE: if (req_valid) begin
                fill_d        = req_fill;
                err_d         = 1'b0;
                wb_addr_d     = req_wb_addr;
                fill_addr_d   = req_fill_addr;
                active_d      = 1'b1;
                active_line_d = req_line;
                state_d       = req_wb ? WB_ISSUE : req_fill ? FILL_ISSUE : DONE;
            end
            WB_ISSUE, FILL_ISSUE: if (!mc_busy) begin
                mc_ce_d        = 1'b1;
                mc_we_d        = is_wb;
                mc_sram_addr_d = line_base;
                mc_ext_addr_d  = is_wb ? wb_addr_q : fill_addr_q;
                state_d        = is_wb ? WB_WAIT_BUSY : FILL_WAIT_BUSY;
            end
            WB_WAIT_BUSY:   if (mc_busy) state_d = WB_WAIT_DONE;
            FILL_WAIT_BUSY: if (mc_busy) state_d = FILL_WAIT_DONE;
            WB_WAIT_DONE: if (!mc_busy) begin
                wb_words_d = mc_progress;
                err_d      = err_q | (mc_progress != 10'(LINE_WORDS));
                state_d    = (err_d || !fill_q) ? DONE : FILL_ISSUE;
            end
            FILL_WAIT_DONE: if (!mc_busy) state_d = DONE;
            DONE: begin
                active_d = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // a timeout only aborts when the controller did not move us on this cycle
        if (expired && state_d == state_q) begin
            err_d   = 1'b1;
            mc_ce_d = 1'b0;
            state_d = DONE;
        end
        cnt_d        = (state_d != state_q || !waiting) ? '0 : cnt_q + 1'b1;
        done_valid_d = (state_d == DONE);
        done_err_d   = (state_d == DONE) && err_d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            cnt_q          <= '0;
            fill_q         <= 1'b0;
            err_q          <= 1'b0;
            wb_addr_q      <= '0;
            fill_addr_q    <= '0;
            mc_ce_q        <= 1'b0;
            mc_we_q        <= 1'b0;
            mc_sram_addr_q <= '0;
            mc_ext_addr_q  <= '0;
            active_q       <= 1'b0;
            active_line_q  <= '0;
            done_valid_q   <= 1'b0;
            done_err_q     <= 1'b0;
            wb_words_q     <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            fill_q         <= fill_d;
            err_q          <= err_d;
            wb_addr_q      <= wb_addr_d;
            fill_addr_q    <= fill_addr_d;
            mc_ce_q        <= mc_ce_d;
            mc_we_q        <= mc_we_d;
            mc_sram_addr_q <= mc_sram_addr_d;
            mc_ext_addr_q  <= mc_ext_addr_d;
            active_q       <= active_d;
            active_line_q  <= active_line_d;
            done_valid_q   <= done_valid_d;
            done_err_q     <= done_err_d;
            wb_words_q     <= wb_words_d;
        end
    end
    assign req_ready    = (state_q == IDLE);
    assign mc_ce        = mc_ce_q;
    assign mc_we        = mc_we_q;
    assign mc_sram_addr = mc_sram_addr_q;
    assign mc_ext_addr  = mc_ext_addr_q;
    assign active       = active_q;
    assign active_line  = active_line_q;
    assign done_valid   = done_valid_q;
    assign done_err     = done_err_q;
    assign wb_words     = wb_words_q;
endmodule

// File: tb/tb_cache_line_sequencer.sv
// tb_cache_line_sequencer: directed bench with a small burst-controller stub
// that logs every ce pulse and can behave normally, stuck, or short.
module tb_cache_line_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_wb = 1'b0, req_fill = 1'b0;
    logic [5:0]  req_line = '0;
    logic [31:0] req_wb_addr = '0, req_fill_addr = '0;
    logic        req_ready, mc_ce, mc_we, active, done_valid, done_err;
    logic [9:0]  mc_sram_addr, wb_words;
    logic [31:0] mc_ext_addr;
    logic [5:0]  active_line;
    logic        mc_busy = 1'b0;
    logic [9:0]  mc_progress = '0;
    int          n_chk = 0, n_fail = 0, mode = 0, ce_n = 0, busy_cnt = 0, viol = 0;
    logic        ce_we[32];
    logic [9:0]  ce_sram[32];
    logic [31:0] ce_ext[32];
    int          cyc, base, v0;
    logic        err;
    always #5 clk = ~clk;
    cache_line_sequencer dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_line(req_line), .req_wb(req_wb), .req_wb_addr(req_wb_addr),
        .req_fill(req_fill), .req_fill_addr(req_fill_addr), .mc_ce(mc_ce),
        .mc_we(mc_we), .mc_sram_addr(mc_sram_addr), .mc_ext_addr(mc_ext_addr),
        .mc_busy(mc_busy), .mc_progress(mc_progress), .active(active),
        .active_line(active_line), .done_valid(done_valid), .done_err(done_err),
        .wb_words(wb_words)
    );
    // mode 0: normal, 1: never goes busy, 2: writeback reports 15 words
    always @(posedge clk) begin
        if (mc_ce) begin
            ce_we[ce_n[4:0]]   <= mc_we;
            ce_sram[ce_n[4:0]] <= mc_sram_addr;
            ce_ext[ce_n[4:0]]  <= mc_ext_addr;
            ce_n               <= ce_n + 1;
            if (mc_busy) viol <= viol + 1;
            if (mode != 1) begin
                mc_busy     <= 1'b1;
                busy_cnt    <= 6;
                mc_progress <= (mode == 2) ? 10'd15 : 10'd16;
            end
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) mc_busy <= 1'b0;
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic do_req(input string tag, input logic [5:0] line, input logic wb,
                          input logic [31:0] wa, input logic fill, input logic [31:0] fa,
                          output int c, output logic e);
        @(negedge clk);
        req_valid = 1'b1; req_line = line; req_wb = wb; req_wb_addr = wa;
        req_fill = fill; req_fill_addr = fa;
        c = 1;
        @(negedge clk);
        req_valid = 1'b0;
        c = 2;
        chk({tag, "_active"}, 32'(active), 1);
        chk({tag, "_line"}, 32'(active_line), 32'(line));
        while (!done_valid && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk({tag, "_done_seen"}, 32'(done_valid), 1);
        chk({tag, "_ready_in_done"}, 32'(req_ready), 0);
        e = done_err;
        @(negedge clk);
        chk({tag, "_ready_after"}, 32'(req_ready), 1);
        chk({tag, "_inactive"}, 32'(active), 0);
        chk({tag, "_done_pulse"}, 32'(done_valid), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_ce", 32'(mc_ce), 0);
        chk("rst_active", 32'(active), 0);
        chk("rst_done", 32'(done_valid), 0);
        chk("rst_ext", mc_ext_addr, 0);
        chk("rst_wbw", 32'(wb_words), 0);
        rst = 1'b0;
        base = ce_n;
        do_req("dirty", 6'd3, 1'b1, 32'h100, 1'b1, 32'h200, cyc, err);
        chk("dirty_ce_count", 32'(ce_n - base), 2);
        chk("dirty_we0", 32'(ce_we[base]), 1);
        chk("dirty_sram0", 32'(ce_sram[base]), 32'h030);
        chk("dirty_ext0", ce_ext[base], 32'h100);
        chk("dirty_we1", 32'(ce_we[base + 1]), 0);
        chk("dirty_sram1", 32'(ce_sram[base + 1]), 32'h030);
        chk("dirty_ext1", ce_ext[base + 1], 32'h200);
        chk("dirty_wbw", 32'(wb_words), 16);
        chk("dirty_err", 32'(err), 0);
        chk("dirty_hold_ext", mc_ext_addr, 32'h200);
        base = ce_n;
        do_req("clean", 6'd0, 1'b0, 32'h0, 1'b1, 32'h40, cyc, err);
        chk("clean_ce_count", 32'(ce_n - base), 1);
        chk("clean_we", 32'(ce_we[base]), 0);
        chk("clean_sram", 32'(ce_sram[base]), 0);
        chk("clean_ext", ce_ext[base], 32'h40);
        chk("clean_err", 32'(err), 0);
        base = ce_n;
        do_req("flush", 6'd9, 1'b1, 32'h500, 1'b0, 32'h600, cyc, err);
        chk("flush_ce_count", 32'(ce_n - base), 1);
        chk("flush_we", 32'(ce_we[base]), 1);
        chk("flush_sram", 32'(ce_sram[base]), 32'h090);
        chk("flush_ext", ce_ext[base], 32'h500);
        chk("flush_err", 32'(err), 0);
        base = ce_n;
        do_req("none", 6'd4, 1'b0, 32'h0, 1'b0, 32'h0, cyc, err);
        chk("none_cycles", 32'(cyc), 2);
        chk("none_ce_count", 32'(ce_n - base), 0);
        chk("none_err", 32'(err), 0);
        mode = 1;
        base = ce_n;
        do_req("stuck", 6'd2, 1'b1, 32'h700, 1'b1, 32'h800, cyc, err);
        chk("stuck_cycles", 32'(cyc), 67);
        chk("stuck_err", 32'(err), 1);
        chk("stuck_ce_count", 32'(ce_n - base), 1);
        mode = 2;
        base = ce_n;
        do_req("short", 6'd1, 1'b1, 32'h900, 1'b1, 32'hA00, cyc, err);
        chk("short_wbw", 32'(wb_words), 15);
        chk("short_err", 32'(err), 1);
        chk("short_ce_count", 32'(ce_n - base), 1);
        mode = 0;
        @(negedge clk);
        req_valid = 1'b1; req_line = 6'd5; req_wb = 1'b1; req_wb_addr = 32'h300;
        req_fill = 1'b1; req_fill_addr = 32'h400;
        @(negedge clk);
        req_valid = 1'b0;
        for (int i = 0; i < 20 && !mc_busy; i++) @(negedge clk);
        chk("mid_busy_seen", 32'(mc_busy), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_active", 32'(active), 0);
        chk("mid_ce", 32'(mc_ce), 0);
        chk("mid_ready", 32'(req_ready), 1);
        chk("mid_busy_still", 32'(mc_busy), 1);
        base = ce_n;
        v0 = viol;
        do_req("after_rst", 6'd7, 1'b0, 32'h0, 1'b1, 32'h80, cyc, err);
        chk("after_rst_no_overlap", 32'(viol - v0), 0);
        chk("after_rst_ce_count", 32'(ce_n - base), 1);
        chk("after_rst_ext", ce_ext[base], 32'h80);
        chk("after_rst_sram", 32'(ce_sram[base]), 32'h070);
        chk("after_rst_err", 32'(err), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
